// File: rtl/lif_pkg.sv
// Shared Q-format constants, FSM state encoding and fixed-point helpers
// for the LIF neuron layer.
package lif_pkg;

    localparam int ACC_BITS  = 8;
    localparam int FRAC_BITS = 6;

    localparam logic signed [ACC_BITS-1:0] SAT_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAK,
        S_ACC,
        S_FIRE,
        S_DONE
    } state_t;

    // Signed add that clamps to the representable range instead of wrapping.
    function automatic logic signed [ACC_BITS-1:0] sat_add(
        input logic signed [ACC_BITS-1:0] a,
        input logic signed [ACC_BITS-1:0] b
    );
        logic signed [ACC_BITS:0] s;
        s = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
        if (s[ACC_BITS] != s[ACC_BITS-1])
            return s[ACC_BITS] ? SAT_MIN : SAT_MAX;
        return s[ACC_BITS-1:0];
    endfunction

    // Q-format multiply: full product, arithmetic shift (floor), then keep
    // the low ACC_BITS of the shifted result (truncating, not saturating).
    function automatic logic signed [ACC_BITS-1:0] fx_mul(
        input logic signed [ACC_BITS-1:0] a,
        input logic signed [ACC_BITS-1:0] b
    );
        logic signed [2*ACC_BITS-1:0] p;
        p = a * b;
        return p[FRAC_BITS+ACC_BITS-1:FRAC_BITS];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Shared combinational datapath: leak multiply in LEAK, gated saturating
// accumulate in ACC, threshold compare / reset-by-subtraction for FIRE.
module lif_update_unit #(
    parameter int ACC_BITS = 8
) (
    input  lif_pkg::state_t             state,
    input  logic signed [ACC_BITS-1:0]  v_cur,
    input  logic signed [ACC_BITS-1:0]  beta,
    input  logic signed [ACC_BITS-1:0]  acc,
    input  logic signed [ACC_BITS-1:0]  w_data,
    input  logic                        spike,
    input  logic signed [ACC_BITS-1:0]  threshold,
    output logic signed [ACC_BITS-1:0]  acc_nx,
    output logic signed [ACC_BITS-1:0]  v_fire,
    output logic                        fire
);
    import lif_pkg::*;

    // Next accumulator value; holds in every state that does not update it.
    always_comb begin
        acc_nx = acc;
        case (state)
            S_LEAK: acc_nx = fx_mul(v_cur, beta);
            S_ACC:  if (spike) acc_nx = sat_add(acc, w_data);
            default: ;
        endcase
    end

    // Threshold is positive, so acc - threshold cannot overflow when firing.
    assign fire   = (acc >= threshold);
    assign v_fire = fire ? (acc - threshold) : acc;

endmodule

// File: rtl/lif_neuron_core.sv
// Time-multiplexed LIF layer: one shared datapath walks all neurons once
// per timestep, fetching weights from an external 1-cycle-latency memory.
module lif_neuron_core #(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 3,
    parameter int ACC_BITS  = 8,
    parameter int FRAC_BITS = 6,
    parameter int AW        = $clog2(N_IN*N_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clear,
    input  logic [N_IN-1:0]             in_spikes,
    input  logic signed [ACC_BITS-1:0]  beta,
    input  logic signed [ACC_BITS-1:0]  threshold,
    output logic [AW-1:0]               w_addr,
    input  logic signed [ACC_BITS-1:0]  w_data,
    output logic [N_OUT-1:0]            out_spikes,
    output logic                        busy,
    output logic                        done
);
    import lif_pkg::*;

    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                     state, state_nx;
    logic [JW-1:0]              j;
    logic [KW-1:0]              k;
    logic                       last_j, last_k;
    logic signed [ACC_BITS-1:0] acc, acc_nx, v_fire, v_cur;
    logic                       fire;
    logic signed [ACC_BITS-1:0] v [N_OUT];
    logic [N_OUT-1:0]           shadow, shadow_nx;
    int                         addr_i;

    assign last_j = (j == JW'(N_OUT-1));
    assign last_k = (k == KW'(N_IN-1));
    assign v_cur  = v[j];
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    lif_update_unit #(.ACC_BITS(ACC_BITS)) u_update (
        .state     (state),
        .v_cur     (v_cur),
        .beta      (beta),
        .acc       (acc),
        .w_data    (w_data),
        .spike     (in_spikes[k]),
        .threshold (threshold),
        .acc_nx    (acc_nx),
        .v_fire    (v_fire),
        .fire      (fire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; start/clear are only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LEAK;
            S_LEAK: state_nx = S_ACC;
            S_ACC:  if (last_k) state_nx = S_FIRE;
            S_FIRE: state_nx = last_j ? S_DONE : S_LEAK;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Weight address runs one cycle ahead of the ACC step that consumes it.
    always_comb begin
        addr_i = 0;
        case (state)
            S_LEAK: addr_i = int'(j) * N_IN;
            S_ACC:  if (!last_k) addr_i = int'(j) * N_IN + int'(k) + 1;
            default: ;
        endcase
    end
    assign w_addr = AW'(addr_i);

    // Neuron index j and input index k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j <= '0;
            k <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    j <= '0;
                    k <= '0;
                end
                S_ACC:  k <= last_k ? '0 : k + KW'(1);
                S_FIRE: j <= last_j ? '0 : j + JW'(1);
                default: ;
            endcase
        end
    end

    // Accumulator follows the datapath, which holds it outside LEAK/ACC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else     acc <= acc_nx;
    end

    // Membrane array: cleared in IDLE (also when start arrives with clear),
    // written back once per neuron in FIRE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_OUT; n++) v[n] <= '0;
        end else if (state == S_IDLE && clear) begin
            for (int n = 0; n < N_OUT; n++) v[n] <= '0;
        end else if (state == S_FIRE) begin
            v[j] <= v_fire;
        end
    end

    // Shadow vector with the current neuron's fire decision merged in.
    always_comb begin
        shadow_nx    = shadow;
        shadow_nx[j] = fire;
    end

    // Spike vectors: out_spikes is published on the edge into DONE so it is
    // already valid while done is high, and never changes mid-timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            out_spikes <= '0;
        end else if (state == S_FIRE) begin
            shadow <= shadow_nx;
            if (last_j) out_spikes <= shadow_nx;
        end
    end

endmodule

// File: tb/tb_lif_neuron_core.sv
// Self-checking bench for lif_neuron_core with a behavioural timestep model.
module tb_lif_neuron_core;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int LAT   = N_OUT * (N_IN + 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              clear;
    logic [3:0]        in_spikes;
    logic signed [7:0] beta;
    logic signed [7:0] threshold;
    logic [3:0]        w_addr;
    logic signed [7:0] w_data;
    logic [2:0]        out_spikes;
    logic              busy;
    logic              done;

    logic signed [7:0] wmem [12];
    int                addr_log [64];
    int                mv [3];
    logic [2:0]        mout;
    int                passed = 0;
    int                total  = 0;

    lif_neuron_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .in_spikes  (in_spikes),
        .beta       (beta),
        .threshold  (threshold),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .out_spikes (out_spikes),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory, one-cycle read latency.
    always @(posedge clk) begin
        if (w_addr < 4'd12) w_data <= wmem[w_addr];
        else                w_data <= '0;
    end

    function automatic int wrap8(input int x);
        logic [7:0] t;
        t = x[7:0];
        return int'($signed(t));
    endfunction

    function automatic int sat8(input int x);
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // Reference timestep from the neuron rules in plain integer arithmetic.
    task automatic model_step(input logic [3:0] spk, input int b, input int th, input bit clr);
        int a;
        if (clr) for (int n = 0; n < 3; n++) mv[n] = 0;
        for (int n = 0; n < 3; n++) begin
            a = wrap8((mv[n] * b) >>> 6);
            for (int i = 0; i < 4; i++)
                if (spk[i]) a = sat8(a + int'(wmem[n*4+i]));
            if (a >= th) begin
                mout[n] = 1'b1;
                mv[n]   = a - th;
            end else begin
                mout[n] = 1'b0;
                mv[n]   = a;
            end
        end
    endtask

    // Drive one start pulse and follow the timestep until done (bounded).
    // Ends on the falling edge of the done cycle; lat = -1 on timeout.
    task automatic run_step(input logic [3:0] spk, input int b, input int th, input bit clr,
                            output int lat);
        @(negedge clk);
        in_spikes = spk;
        beta      = 8'(b);
        threshold = 8'(th);
        start     = 1'b1;
        clear     = clr;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        lat   = -1;
        for (int c = 0; c < 60; c++) begin
            addr_log[c] = int'(w_addr);
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; clear = 0; in_spikes = 0; beta = 0; threshold = 8'sd64;
        repeat (3) @(negedge clk);
        total++;
        if ({out_spikes, busy, done} !== 5'b0) $display("FAIL reset_outputs: got %b required 00000", {out_spikes, busy, done});
        else passed++;
        total++;
        if (w_addr !== 4'd0) $display("FAIL reset_waddr: got %0d required 0", w_addr);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_spikes, busy, done} !== 5'b0) $display("FAIL idle_after_reset: got %b required 00000", {out_spikes, busy, done});
        else passed++;
        for (int n = 0; n < 3; n++) mv[n] = 0;
        mout = '0;
    endtask

    task automatic test_single_fire();
        int lat;
        for (int a = 0; a < 12; a++) wmem[a] = '0;
        wmem[0] = 8'sd80;
        run_step(4'b0001, 32, 64, 1'b1, lat);
        model_step(4'b0001, 32, 64, 1'b1);
        total++;
        if (lat !== LAT) $display("FAIL single_latency: got %0d required %0d", lat, LAT);
        else passed++;
        total++;
        if (out_spikes !== 3'b001) $display("FAIL single_out: got %b required 001", out_spikes);
        else passed++;
        total++;
        if (int'(dut.v[0]) !== 16) $display("FAIL single_v0: got %0d required 16", dut.v[0]);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL single_idle: got busy=%b done=%b required 0 0", busy, done);
        else passed++;
        run_step(4'b0000, 32, 64, 1'b0, lat);
        model_step(4'b0000, 32, 64, 1'b0);
        total++;
        if (out_spikes !== 3'b000) $display("FAIL leak_out: got %b required 000", out_spikes);
        else passed++;
        total++;
        if (int'(dut.v[0]) !== 8) $display("FAIL leak_v0: got %0d required 8", dut.v[0]);
        else passed++;
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < 4; i++) begin
            wmem[i]     = 8'sd0;
            wmem[4+i]   = 8'sd100;
            wmem[8+i]   = -8'sd100;
        end
        run_step(4'b1111, 32, 64, 1'b1, lat);
        model_step(4'b1111, 32, 64, 1'b1);
        total++;
        if (out_spikes !== 3'b010) $display("FAIL sat_out: got %b required 010", out_spikes);
        else passed++;
        total++;
        if (int'(dut.v[1]) !== 63) $display("FAIL sat_v1: got %0d required 63", dut.v[1]);
        else passed++;
        total++;
        if (int'(dut.v[2]) !== -128) $display("FAIL sat_v2: got %0d required -128", dut.v[2]);
        else passed++;
    endtask

    task automatic test_leak_floor();
        int lat;
        run_step(4'b0000, 32, 64, 1'b0, lat);
        model_step(4'b0000, 32, 64, 1'b0);
        total++;
        if (int'(dut.v[2]) !== -64) $display("FAIL floor_m128: got %0d required -64", dut.v[2]);
        else passed++;
        for (int a = 0; a < 12; a++) wmem[a] = '0;
        wmem[0] = -8'sd1;
        run_step(4'b0001, 32, 64, 1'b1, lat);
        model_step(4'b0001, 32, 64, 1'b1);
        run_step(4'b0000, 32, 64, 1'b0, lat);
        model_step(4'b0000, 32, 64, 1'b0);
        total++;
        if (int'(dut.v[0]) !== -1) $display("FAIL floor_m1: got %0d required -1", dut.v[0]);
        else passed++;
    endtask

    task automatic test_threshold_boundary();
        int lat;
        for (int a = 0; a < 12; a++) wmem[a] = '0;
        wmem[0] = 8'sd64;
        wmem[4] = 8'sd63;
        run_step(4'b0001, 32, 64, 1'b1, lat);
        model_step(4'b0001, 32, 64, 1'b1);
        total++;
        if (out_spikes !== 3'b001) $display("FAIL thr_out: got %b required 001", out_spikes);
        else passed++;
        total++;
        if (int'(dut.v[0]) !== 0 || int'(dut.v[1]) !== 63) $display("FAIL thr_v: got %0d,%0d required 0,63", dut.v[0], dut.v[1]);
        else passed++;
    endtask

    task automatic test_waddr();
        int lat;
        for (int a = 0; a < 12; a++) wmem[a] = 8'($urandom_range(0, 255));
        run_step(4'b1011, 40, 50, 1'b0, lat);
        model_step(4'b1011, 40, 50, 1'b0);
        for (int n = 0; n < 3; n++)
            for (int m = 0; m < 4; m++) begin
                total++;
                if (addr_log[n*6+m] !== n*4+m)
                    $display("FAIL waddr_j%0d_k%0d: got %0d required %0d", n, m, addr_log[n*6+m], n*4+m);
                else passed++;
            end
        total++;
        if (out_spikes !== mout) $display("FAIL waddr_out: got %b required %b", out_spikes, mout);
        else passed++;
    endtask

    task automatic test_handshake();
        int lat;
        @(negedge clk);
        in_spikes = 4'b0110; beta = 8'sd48; threshold = 8'sd30; start = 1'b1; clear = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            start = (c == 5 || c == 11);
            clear = (c == 5 || c == 7);
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        clear = 1'b0;
        model_step(4'b0110, 48, 30, 1'b0);
        total++;
        if (lat !== LAT) $display("FAIL busy_latency: got %0d required %0d", lat, LAT);
        else passed++;
        total++;
        if (out_spikes !== mout) $display("FAIL busy_out: got %b required %b", out_spikes, mout);
        else passed++;
        for (int n = 0; n < 3; n++) begin
            total++;
            if (int'(dut.v[n]) !== mv[n]) $display("FAIL busy_v%0d: got %0d required %0d", n, dut.v[n], mv[n]);
            else passed++;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0) $display("FAIL no_queue_c%0d: got busy=%b done=%b required 0 0", c, busy, done);
            else passed++;
        end
        // start together with clear: membranes zeroed before the run
        run_step(4'b1001, 100, 20, 1'b1, lat);
        model_step(4'b1001, 100, 20, 1'b1);
        total++;
        if (out_spikes !== mout) $display("FAIL startclr_out: got %b required %b", out_spikes, mout);
        else passed++;
        for (int n = 0; n < 3; n++) begin
            total++;
            if (int'(dut.v[n]) !== mv[n]) $display("FAIL startclr_v%0d: got %0d required %0d", n, dut.v[n], mv[n]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int lat, b, th;
        logic [3:0] spk;
        bit clr;
        for (int t = 0; t < 25; t++) begin
            if (t % 5 == 0)
                for (int a = 0; a < 12; a++) wmem[a] = 8'($urandom_range(0, 255));
            spk = 4'($urandom_range(0, 15));
            b   = $urandom_range(0, 127);
            th  = $urandom_range(1, 127);
            clr = ($urandom_range(0, 4) == 0);
            run_step(spk, b, th, clr, lat);
            model_step(spk, b, th, clr);
            total++;
            if (lat !== LAT) $display("FAIL rand%0d_latency: got %0d required %0d", t, lat, LAT);
            else passed++;
            total++;
            if (out_spikes !== mout) $display("FAIL rand%0d_out: got %b required %b", t, out_spikes, mout);
            else passed++;
            for (int n = 0; n < 3; n++) begin
                total++;
                if (int'(dut.v[n]) !== mv[n]) $display("FAIL rand%0d_v%0d: got %0d required %0d", t, n, dut.v[n], mv[n]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        for (int a = 0; a < 12; a++) wmem[a] = '0;
        wmem[0] = 8'sd80;
        run_step(4'b0001, 32, 64, 1'b1, lat);
        model_step(4'b0001, 32, 64, 1'b1);
        total++;
        if (out_spikes !== 3'b001) $display("FAIL pre_abort_out: got %b required 001", out_spikes);
        else passed++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({out_spikes, busy, done} !== 5'b0) $display("FAIL abort_outputs: got %b required 00000", {out_spikes, busy, done});
        else passed++;
        total++;
        if (int'(dut.v[0]) !== 0) $display("FAIL abort_v0: got %0d required 0", dut.v[0]);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) mv[n] = 0;
        wmem[0] = '0;
        run_step(4'b1111, 32, 64, 1'b0, lat);
        model_step(4'b1111, 32, 64, 1'b0);
        total++;
        if (lat !== LAT) $display("FAIL post_abort_latency: got %0d required %0d", lat, LAT);
        else passed++;
        total++;
        if (out_spikes !== 3'b000) $display("FAIL post_abort_out: got %b required 000", out_spikes);
        else passed++;
    endtask

    initial begin
        for (int a = 0; a < 12; a++) wmem[a] = '0;
        test_reset();
        test_single_fire();
        test_saturation();
        test_leak_floor();
        test_threshold_boundary();
        test_waddr();
        test_handshake();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
